// File: rtl/seq_mult_ctrl_dp_if.sv
// seq_mult_ctrl_dp_if: start/busy/done handshake and operand/result bus for
// the shift-add sequential multiplier. When SEQ_MULT_SIGNED_EN is defined,
// the bus also carries signed_mode, which is sampled together with start.
interface seq_mult_ctrl_dp_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
`ifdef SEQ_MULT_SIGNED_EN
    logic               signed_mode;
`endif
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

`ifdef SEQ_MULT_SIGNED_EN
    modport master (output start, mcand, mplier, signed_mode,
                    input  product, busy, done);
    modport slave  (input  start, mcand, mplier, signed_mode,
                    output product, busy, done);
`else
    modport master (output start, mcand, mplier,
                    input  product, busy, done);
    modport slave  (input  start, mcand, mplier,
                    output product, busy, done);
`endif
endinterface

// File: rtl/seq_mult_ctrl_dp.sv
// seq_mult_ctrl_dp: WIDTH-bit shift-add sequential multiplier, with the
// controller and the datapath in one block. Latency is fixed at 2*WIDTH+1
// cycles from the start-accept edge to the cycle in which done is high.
// Optional build macro: SEQ_MULT_SIGNED_EN adds two's-complement operands,
// which are selected per operation by signed_mode.
module seq_mult_ctrl_dp #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic               clk,
    input logic               rst,
    seq_mult_ctrl_dp_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   mreg_q, mreg_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH-1:0]   ld_mc, ld_mp;
    logic [2*WIDTH-1:0] fin_val;
`ifdef SEQ_MULT_SIGNED_EN
    logic               sign_q, sign_d;
`endif

    // The carry bit drops into the top of acc, and mreg[0] is consumed.
    assign shifted = {carry_q, acc_q, mreg_q[WIDTH-1:1]};

    // Operand load values (magnitudes in signed mode) and the final product value.
    always_comb begin
        ld_mc   = bus.mcand;
        ld_mp   = bus.mplier;
        fin_val = shifted;
`ifdef SEQ_MULT_SIGNED_EN
        if (bus.signed_mode) begin
            // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
            if (bus.mcand[WIDTH-1])  ld_mc = -bus.mcand;
            if (bus.mplier[WIDTH-1]) ld_mp = -bus.mplier;
        end
        if (sign_q) fin_val = -shifted;
`endif
    end

    // Next-state logic for the controller and the datapath registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        mreg_d    = mreg_q;
        mc_d      = mc_q;
        count_d   = count_q;
        product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mc_d    = ld_mc;
                    mreg_d  = ld_mp;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d  = bus.signed_mode & (bus.mcand[WIDTH-1] ^ bus.mplier[WIDTH-1]);
`endif
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (mreg_q[0]) {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, mc_q};
                else           carry_d = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                acc_d   = shifted[2*WIDTH-1:WIDTH];
                mreg_d  = shifted[WIDTH-1:0];
                carry_d = 1'b0;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = fin_val;
                    state_d   = S_FIN;
                end else begin
                    state_d   = S_ADD;
                end
            end
            default: state_d = S_IDLE;   // S_FIN: a single-cycle done pulse
        endcase
    end

    // State registers with a synchronous active-low reset. Reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            mreg_q    <= '0;
            mc_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            mreg_q    <= mreg_d;
            mc_q      <= mc_d;
            count_q   <= count_d;
            product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_FIN);
endmodule

// File: tb/tb_seq_mult_ctrl_dp.sv
// tb_seq_mult_ctrl_dp: directed vectors with a scoreboard. The stimulus pushes
// the expected product and the expected done cycle; the monitor pops and
// compares them whenever done is high.
module tb_seq_mult_ctrl_dp;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_mult_ctrl_dp_if #(.WIDTH(W)) bus();
    seq_mult_ctrl_dp #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: each done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 64'(bus.product), 64'(e.prod));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_with_done", 64'(bus.busy), 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge while the DUT is idle; returns in cycle 1 of the operation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [2*W-1:0] exp);
        exp_t e;
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
`ifdef SEQ_MULT_SIGNED_EN
        bus.signed_mode = sm;
`else
        if (sm) $display("note: signed_mode request ignored in unsigned build");
`endif
        e.prod = exp;
        e.cyc  = cyc + 1 + 2*W;
        sb.push_back(e);
        tick();
        bus.start  = 1'b0;
        bus.mcand  = '1;        // operands may change freely after acceptance
        bus.mplier = 8'h5A;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;
`ifdef SEQ_MULT_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif
        rst = 1'b0;
        tick();
        tick();
        check("reset_product", 64'(bus.product), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        tick();

        issue(8'd13, 8'd11, 1'b0, 16'd143);
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        wait_idle();
        repeat (3) tick();
        check("product_held_idle", 64'(bus.product), 64'd143);

        issue(8'd255, 8'd255, 1'b0, 16'd65025);
        wait_idle();
        issue(8'd0, 8'd200, 1'b0, 16'd0);
        wait_idle();
        issue(8'd1, 8'd255, 1'b0, 16'd255);
        wait_idle();
        issue(8'd128, 8'd2, 1'b0, 16'd256);
        wait_idle();

        // Start pulses in cycles 3, 10 and the FIN cycle (17) must all be ignored.
        issue(8'd7, 8'd9, 1'b0, 16'd63);
        for (int k = 1; k <= 17; k++) begin
            bus.start  = (k == 3 || k == 10 || k == 17);
            bus.mcand  = 8'd50;
            bus.mplier = 8'd50;
            tick();
        end
        bus.start = 1'b0;
        check("idle_after_ignored_starts", 64'(bus.busy), 64'd0);
        check("product_after_ignored", 64'(bus.product), 64'd63);
        tick();

        // Start held high: accepts every 18 cycles; dropped after the third accept.
        for (int j = 0; j < 3; j++) begin
            exp_t e;
            e.prod = 16'd42;
            e.cyc  = cyc + 1 + 2*W + 18*j;
            sb.push_back(e);
        end
        bus.start  = 1'b1;
        bus.mcand  = 8'd6;
        bus.mplier = 8'd7;
        repeat (37) tick();
        bus.start = 1'b0;
        wait_idle();

        // Reset in cycle 6 of a 100*3 operation: the operation is abandoned with no done pulse.
        bus.start  = 1'b1;
        bus.mcand  = 8'd100;
        bus.mplier = 8'd3;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_product", 64'(bus.product), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        repeat (20) tick();
        check("abort_no_done_product", 64'(bus.product), 64'd0);
        issue(8'd100, 8'd3, 1'b0, 16'd300);
        wait_idle();

`ifdef SEQ_MULT_SIGNED_EN
        issue(8'hFD, 8'd5, 1'b1, 16'hFFF1);
        wait_idle();
        issue(8'h80, 8'h80, 1'b1, 16'h4000);
        wait_idle();
        issue(8'd127, 8'hFF, 1'b1, 16'hFF81);
        wait_idle();
        issue(8'hFD, 8'd5, 1'b0, 16'd1265);
        wait_idle();
`endif

        repeat (4) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
